// File: rtl/music_pkg.sv
// Shared definitions for the polyphonic music player: mixer states, sample limits, saturation.
package music_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        REQUEST    = 2'd1,
        COLLECT    = 2'd2,
        MIX        = 2'd3
    } mixer_state_t;

    localparam int DEFAULT_SAMPLE_W = 16;
    localparam int SAMPLE_MAX       = (2 ** (DEFAULT_SAMPLE_W - 1)) - 1;
    localparam int SAMPLE_MIN       = -(2 ** (DEFAULT_SAMPLE_W - 1));

    // Clamp x to the signed range of a w-bit sample.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/frame_sync.sv
// Two-flop synchroniser plus registered rising-edge pulse for codec-side strobes.
module frame_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);
    logic sync0;
    logic sync1;
    logic sync2;

    // Raw edge to pulse is three clk: two synchroniser stages plus the registered detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync0 <= async_in;
            sync1 <= sync0;
            sync2 <= sync1;
            pulse <= sync1 & ~sync2;
        end
    end

endmodule

// File: rtl/poly_voice_mixer.sv
// Frame-synchronous mixer: requests, collects, sums, scales and saturates NUM_VOICES samples.
// Optional MIXER_VOLUME_RAMP_EN adds a per-frame volume ramp (also used for mute fades).
module poly_voice_mixer
    import music_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
    parameter int VOL_W      = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           New_Frame,
    input  logic [NUM_VOICES-1:0]          voice_enable,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_ready,
    input  logic [VOL_W-1:0]               volume,
    input  logic                           mute,
    output logic                           generate_next_sample,
    output logic [SAMPLE_W-1:0]            sample_out,
    output logic                           clip,
    output logic                           underrun,
    output mixer_state_t                   state_dbg
);
    localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES);
    localparam int PROD_W = SUM_W + VOL_W + 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    mixer_state_t                state;
    logic                        frame_edge;
    logic [NUM_VOICES-1:0]       mask;
    logic [NUM_VOICES-1:0]       mask_next;
    logic                        all_in;
    logic signed [SAMPLE_W-1:0]  lat [NUM_VOICES];
    logic [CNT_W-1:0]            cnt;
    logic [SAMPLE_W-1:0]         mix_reg;
    logic [VOL_W-1:0]            gain;
    logic signed [SUM_W-1:0]     sum;
    logic signed [PROD_W-1:0]    prod;
    logic signed [31:0]          prod32;
    logic signed [31:0]          sat32;
    logic [SAMPLE_W-1:0]         mix_val;
    logic                        mix_clip;

    frame_sync u_frame_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (New_Frame),
        .pulse    (frame_edge)
    );

`ifdef MIXER_VOLUME_RAMP_EN
    logic [VOL_W-1:0] eff_vol;
    logic [VOL_W-1:0] vol_target;

    assign vol_target = mute ? '0 : volume;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eff_vol <= '0;
        end else if (frame_edge) begin
            if (eff_vol < vol_target) eff_vol <= eff_vol + 1'b1;
            else if (eff_vol > vol_target) eff_vol <= eff_vol - 1'b1;
        end
    end

    assign gain = eff_vol;
`else
    assign gain = volume;
`endif

    assign mask_next = mask | voice_ready;
    assign all_in    = &(mask_next | ~voice_enable);
    assign state_dbg = state;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_enable[i] && mask[i]) sum = sum + SUM_W'(lat[i]);
        end
        prod     = PROD_W'(sum) * PROD_W'($signed({1'b0, gain}));
        prod32   = {{(32 - PROD_W){prod[PROD_W-1]}}, prod};
        prod32   = prod32 >>> VOL_W;
        sat32    = saturate(prod32, SAMPLE_W);
        mix_clip = (sat32 != prod32);
        mix_val  = sat32[SAMPLE_W-1:0];
`ifndef MIXER_VOLUME_RAMP_EN
        if (mute) begin
            mix_val  = '0;
            mix_clip = 1'b0;
        end
`endif
    end

    // A frame edge always wins: it publishes mix_reg and restarts collection, whatever the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= WAIT_FRAME;
            generate_next_sample <= 1'b0;
            sample_out           <= '0;
            clip                 <= 1'b0;
            underrun             <= 1'b0;
            mix_reg              <= '0;
            mask                 <= '0;
            cnt                  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) lat[i] <= '0;
        end else begin
            generate_next_sample <= 1'b0;
            if (frame_edge) begin
                sample_out           <= mix_reg;
                if (state != WAIT_FRAME) underrun <= 1'b1;
                state                <= REQUEST;
                generate_next_sample <= 1'b1;
            end else begin
                case (state)
                    WAIT_FRAME: ;
                    REQUEST: begin
                        mask <= voice_ready;
                        for (int i = 0; i < NUM_VOICES; i++)
                            lat[i] <= voice_ready[i] ? voice_sample[i*SAMPLE_W +: SAMPLE_W] : '0;
                        cnt   <= CNT_W'(TIMEOUT);
                        state <= COLLECT;
                    end
                    COLLECT: begin
                        for (int i = 0; i < NUM_VOICES; i++)
                            if (voice_ready[i]) lat[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
                        mask <= mask_next;
                        cnt  <= cnt - 1'b1;
                        if (all_in || cnt <= CNT_W'(1)) state <= MIX;
                    end
                    MIX: begin
                        mix_reg <= mix_val;
                        if (mix_clip) clip <= 1'b1;
                        state <= WAIT_FRAME;
                    end
                    default: state <= WAIT_FRAME;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Self-checking bench for poly_voice_mixer: vector table, frame scoreboard, corner sequences.
module tb_poly_voice_mixer;
    import music_pkg::*;

    localparam int NV = 3;
    localparam int SW = 16;
    localparam int VW = 4;

    typedef struct {
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;
        logic [SW-1:0] s2;
        logic [NV-1:0] en;
        logic [NV-1:0] rdy;
        logic [VW-1:0] vol;
        logic          mute;
        logic [SW-1:0] exp_out;
        logic          exp_clip;
        int            exp_cyc;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             New_Frame = 1'b0;
    logic [NV-1:0]    voice_enable = '0;
    logic [NV*SW-1:0] voice_sample = '0;
    logic [NV-1:0]    voice_ready = '0;
    logic [VW-1:0]    volume = '0;
    logic             mute = 1'b0;
    logic             generate_next_sample;
    logic [SW-1:0]    sample_out;
    logic             clip;
    logic             underrun;
    mixer_state_t     state_dbg;

    logic [SW-1:0]    exp_q[$];
    logic [SW-1:0]    last_out;
    logic             exp_underrun;
    int               total = 0;
    int               bad = 0;
    vec_t             vecs[11];
    vec_t             zero_row;

    poly_voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .VOL_W(VW), .TIMEOUT(20)) dut (
        .clk                  (clk),
        .reset                (reset),
        .New_Frame            (New_Frame),
        .voice_enable         (voice_enable),
        .voice_sample         (voice_sample),
        .voice_ready          (voice_ready),
        .volume               (volume),
        .mute                 (mute),
        .generate_next_sample (generate_next_sample),
        .sample_out           (sample_out),
        .clip                 (clip),
        .underrun             (underrun),
        .state_dbg            (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_gen(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!generate_next_sample && n < 12);
        check(name, 32'(generate_next_sample), 32'd1);
    endtask

    task automatic pop_check(input string name);
        logic [SW-1:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_q_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(sample_out), 32'(e));
            last_out = e;
        end
    endtask

    // One full frame: edge, check published sample, feed voices, wait for the mix.
    task automatic run_frame(input vec_t v, input string name);
        int cyc;
        int n;
        @(negedge clk);
        New_Frame = 1'b1;
        wait_gen({name, "_gen"});
        pop_check({name, "_sample_out"});
        voice_enable = v.en;
        volume       = v.vol;
        mute         = v.mute;
        @(negedge clk);
        check({name, "_gen_one_cycle"}, 32'(generate_next_sample), 32'd0);
        voice_sample = {v.s2, v.s1, v.s0};
        voice_ready  = v.rdy;
        cyc = (state_dbg == COLLECT) ? 1 : 0;
        n = 0;
        do begin
            @(negedge clk);
            voice_ready = '0;
            if (state_dbg == COLLECT) cyc++;
            n++;
        end while (state_dbg != WAIT_FRAME && n < 60);
        check({name, "_collect_cycles"}, 32'(cyc), 32'(v.exp_cyc));
        check({name, "_clip"}, 32'(clip), 32'(v.exp_clip));
        check({name, "_underrun"}, 32'(underrun), 32'(exp_underrun));
        exp_q.push_back(v.exp_out);
        New_Frame = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{16'sd1000, 16'sd2000, -16'sd500, 3'b111, 3'b111, 4'd15, 1'b0, 16'sd2343, 1'b0, 1};
        vecs[1]  = '{16'sd100, 16'sd200, 16'sd300, 3'b111, 3'b111, 4'd8, 1'b0, 16'sd300, 1'b0, 1};
        vecs[2]  = '{-16'sd1000, -16'sd2000, -16'sd3000, 3'b111, 3'b111, 4'd15, 1'b0, -16'sd5625, 1'b0, 1};
        vecs[3]  = '{-16'sd1, 16'sd0, 16'sd0, 3'b111, 3'b111, 4'd15, 1'b0, -16'sd1, 1'b0, 1};
        vecs[4]  = '{16'sd1000, 16'sd7777, 16'sd3000, 3'b101, 3'b101, 4'd15, 1'b0, 16'sd3750, 1'b0, 1};
        vecs[5]  = '{16'sd1000, 16'sd1000, 16'sd1000, 3'b111, 3'b111, 4'd15, 1'b1, 16'sd0, 1'b0, 1};
        vecs[6]  = '{16'sd5, 16'sd6, 16'sd7, 3'b000, 3'b000, 4'd15, 1'b0, 16'sd0, 1'b0, 1};
        vecs[7]  = '{16'sd10, 16'sd20, 16'sd30, 3'b111, 3'b011, 4'd15, 1'b0, 16'sd28, 1'b0, 20};
        vecs[8]  = '{16'sd32767, 16'sd32767, 16'sd32767, 3'b111, 3'b111, 4'd15, 1'b0, 16'sd32767, 1'b1, 1};
        vecs[9]  = '{-16'sd32768, -16'sd32768, -16'sd32768, 3'b111, 3'b111, 4'd15, 1'b0, 16'h8000, 1'b1, 1};
        vecs[10] = '{16'sd5000, 16'sd5000, 16'sd5000, 3'b111, 3'b111, 4'd0, 1'b0, 16'sd0, 1'b1, 1};
        zero_row = '{16'sd0, 16'sd0, 16'sd0, 3'b000, 3'b000, 4'd0, 1'b0, 16'sd0, 1'b1, 1};

        // reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sample_out", 32'(sample_out), 32'd0);
        check("rst_gen", 32'(generate_next_sample), 32'd0);
        check("rst_clip", 32'(clip), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(WAIT_FRAME));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        exp_underrun = 1'b0;
        exp_q.push_back('0);

        for (int i = 0; i < 11; i++) run_frame(vecs[i], $sformatf("vec%0d", i));
        run_frame(zero_row, "flush");

        // frame edge injected mid-COLLECT
        @(negedge clk);
        New_Frame = 1'b1;
        wait_gen("ur_gen");
        pop_check("ur_first_out");
        voice_enable = 3'b111;
        volume = 4'd15;
        mute = 1'b0;
        @(negedge clk);
        New_Frame = 1'b0;
        @(negedge clk);
        New_Frame = 1'b1;
        wait_gen("ur_regen");
        check("ur_underrun", 32'(underrun), 32'd1);
        check("ur_repeat_out", 32'(sample_out), 32'(last_out));
        check("ur_state", 32'(state_dbg), 32'(REQUEST));
        exp_underrun = 1'b1;
        @(negedge clk);
        voice_sample = {-16'sd500, 16'sd2000, 16'sd1000};
        voice_ready = 3'b111;
        @(negedge clk);
        voice_ready = '0;
        repeat (3) @(negedge clk);
        check("ur_done_state", 32'(state_dbg), 32'(WAIT_FRAME));
        exp_q.push_back(16'sd2343);
        New_Frame = 1'b0;
        repeat (3) @(negedge clk);
        run_frame(zero_row, "ur_next");

        // reset during COLLECT
        @(negedge clk);
        New_Frame = 1'b1;
        wait_gen("rc_gen");
        pop_check("rc_out");
        voice_enable = 3'b111;
        repeat (3) @(negedge clk);
        check("rc_in_collect", 32'(state_dbg), 32'(COLLECT));
        reset = 1'b1;
        #1;
        check("rc_sample_out", 32'(sample_out), 32'd0);
        check("rc_clip", 32'(clip), 32'd0);
        check("rc_underrun", 32'(underrun), 32'd0);
        check("rc_state", 32'(state_dbg), 32'(WAIT_FRAME));
        New_Frame = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        begin
            int gens = 0;
            repeat (12) begin
                @(negedge clk);
                if (generate_next_sample) gens++;
            end
            check("rc_no_request", 32'(gens), 32'd0);
        end
        exp_q.delete();
        exp_q.push_back('0);
        exp_underrun = 1'b0;
        vecs[0].exp_clip = 1'b0;
        zero_row.exp_clip = 1'b0;
        run_frame(vecs[0], "post_rst");
        run_frame(zero_row, "post_rst_flush");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
